// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// register bit positions, framing FSM encodings and the rib slot base address.
package uart_tx_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_BAUD   = 2'd2;
  localparam logic [1:0] ADDR_TXDATA = 2'd3;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_OVF   = 3;
  localparam int STATUS_COUNT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [31:0] RIB_S3_BASE = 32'h3000_0000;

  // A divider of zero would stall the line, so it behaves as one cycle per bit.
  function automatic logic [15:0] bit_period(input logic [15:0] baud);
    return (baud == 16'd0) ? 16'd1 : baud;
  endfunction

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [4:0]       count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full and empty come from pre-edge state, so a pop never makes room for a same-edge push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// rib slave UART transmitter: register file, TX FIFO, baud counter and 8N1
// framing FSM driving a registered, idle-high serial line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        int_signal_o
);

  logic        tx_en_q, tx_en_d, int_en_q, int_en_d, overflow_q, overflow_d;
  logic [15:0] baud_q, baud_d, cnt_q, cnt_d, period_m1;
  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, fifo_head;
  logic        tx_q, tx_d;
  logic [1:0]  reg_sel;
  logic        push, pop, can_start, busy;
  logic        fifo_full, fifo_empty;
  logic [4:0]  fifo_count;
  logic        unused_bits;

  assign reg_sel     = addr_i[3:2];
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16]};
  assign push        = we_i && (reg_sel == ADDR_TXDATA);
  assign can_start   = tx_en_q && !fifo_empty;
  assign busy        = (state_q != ST_IDLE);
  assign period_m1   = bit_period(baud_q) - 16'd1;

  uart_tx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata_i[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    tx_en_d    = tx_en_q;
    int_en_d   = int_en_q;
    baud_d     = baud_q;
    overflow_d = overflow_q;
    if (we_i && reg_sel == ADDR_CTRL) begin
      tx_en_d  = wdata_i[CTRL_TX_EN];
      int_en_d = wdata_i[CTRL_INT_EN];
    end
    if (we_i && reg_sel == ADDR_BAUD) baud_d = wdata_i[15:0];
    if (we_i && reg_sel == ADDR_STATUS && wdata_i[STATUS_OVF]) overflow_d = 1'b0;
    if (push && fifo_full) overflow_d = 1'b1;
  end

  // Each bit holds for cnt reload + 1 cycles; the reload reads BAUD at every boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          state_d = ST_START;
          tx_d    = 1'b0;
          cnt_d   = period_m1;
        end
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = period_m1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = period_m1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          if (can_start) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
            tx_d    = 1'b0;
            cnt_d   = period_m1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en_q    <= 1'b0;
      int_en_q   <= 1'b0;
      baud_q     <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_en_q    <= tx_en_d;
      int_en_q   <= int_en_d;
      baud_q     <= baud_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign int_signal_o = int_en_q && fifo_empty && !busy;

  always_comb begin
    rdata_o = '0;
    case (reg_sel)
      ADDR_CTRL:   rdata_o[1:0] = {int_en_q, tx_en_q};
      ADDR_STATUS: rdata_o[8:0] = {fifo_count, overflow_q, fifo_empty, fifo_full, busy};
      ADDR_BAUD:   rdata_o[15:0] = baud_q;
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level model (byte queue plus a
// ten-level frame with per-level hold time) is compared against tx_o and
// int_signal_o on every falling edge, with directed and random traffic.
module tb_uart_tx;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_BAUD   = 32'h8;
  localparam logic [31:0] A_TX     = 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        intSig;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: FIFO as a queue, registers, and the frame in flight.
  byte unsigned mQ[$];
  bit           mTxEn = 1'b0;
  bit           mIntEn = 1'b0;
  bit           mOvf = 1'b0;
  logic [15:0]  mBaud = 16'd434;
  bit           mBusy = 1'b0;
  bit           mFrame[10];
  int           mBitIdx = 0;
  int           mRemain = 0;

  bit pat[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .tx_o         (tx),
    .int_signal_o (intSig)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit expTx();
    return mBusy ? mFrame[mBitIdx] : 1'b1;
  endfunction

  function automatic bit expInt();
    return mIntEn && (mQ.size() == 0) && !mBusy;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    case (a)
      2'd0:    return {30'd0, mIntEn, mTxEn};
      2'd1:    return {23'd0, 5'(mQ.size()), mOvf, (mQ.size() == 0), (mQ.size() == DEPTH), mBusy};
      2'd2:    return {16'd0, mBaud};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelReset();
    mQ.delete();
    mTxEn = 1'b0;
    mIntEn = 1'b0;
    mOvf = 1'b0;
    mBaud = 16'd434;
    mBusy = 1'b0;
    mBitIdx = 0;
    mRemain = 0;
  endfunction

  function automatic void startFrame(input int period);
    byte unsigned b;
    b = mQ.pop_front();
    mFrame[0] = 1'b0;
    for (int i = 0; i < 8; i++) mFrame[i+1] = b[i];
    mFrame[9] = 1'b1;
    mBitIdx = 0;
    mRemain = period;
    mBusy = 1'b1;
  endfunction

  // The model advances on every rising edge using the pre-edge register values,
  // then applies that edge's bus write.
  initial begin : modelProc
    int period;
    int preSize;
    bit canStart;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        modelReset();
      end else begin
        period = (mBaud == 16'd0) ? 1 : int'(mBaud);
        preSize = mQ.size();
        canStart = mTxEn && (preSize > 0);
        if (mBusy) begin
          mRemain--;
          if (mRemain == 0) begin
            if (mBitIdx == 9) begin
              if (canStart) startFrame(period);
              else mBusy = 1'b0;
            end else begin
              mBitIdx++;
              mRemain = period;
            end
          end
        end else if (canStart) begin
          startFrame(period);
        end
        if (we) begin
          case (addr[3:2])
            2'd0: begin
              mTxEn = wdata[0];
              mIntEn = wdata[1];
            end
            2'd1: if (wdata[3]) mOvf = 1'b0;
            2'd2: mBaud = wdata[15:0];
            default: begin
              if (preSize < DEPTH) mQ.push_back(wdata[7:0]);
              else mOvf = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Compare the serial line and the interrupt against the model every cycle.
  initial begin : compareProc
    forever begin
      @(negedge clk);
      checkOutput("tx_o", {31'd0, tx}, {31'd0, expTx()});
      checkOutput("int_signal_o", {31'd0, intSig}, {31'd0, expInt()});
    end
  end

  // One-cycle bus write; returns on the falling edge after the write edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    addr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic readLit(input string name, input logic [31:0] a, input logic [31:0] lit);
    addr = a;
    #1;
    checkOutput(name, rdata, lit);
    checkOutput({name, "Model"}, rdata, modelRead(a[3:2]));
  endtask

  task automatic readModel(input string name, input logic [31:0] a);
    addr = a;
    #1;
    checkOutput(name, rdata, modelRead(a[3:2]));
  endtask

  initial begin : mainProc
    int op;
    logic [31:0] r1, r2, d;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    readLit("resetStatus", A_STATUS, 32'h4);
    readLit("resetBaud", A_BAUD, 32'd434);
    readLit("resetCtrl", A_CTRL, 32'h0);
    checkOutput("resetTx", {31'd0, tx}, 32'd1);
    checkOutput("resetInt", {31'd0, intSig}, 32'd0);

    // Single 0xA5 frame at 4 cycles per bit
    applyStimulus(A_BAUD, 32'd4);
    applyStimulus(A_CTRL, 32'd1);
    @(negedge clk);
    we = 1'b1;
    addr = A_TX;
    wdata = 32'hA5;
    @(negedge clk);
    we = 1'b0;
    addr = A_STATUS;
    checkOutput("a5PreStart", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      checkOutput("a5Bit", {31'd0, tx}, {31'd0, pat[i/4]});
      checkOutput("a5Busy", {31'd0, rdata[0]}, 32'd1);
    end
    @(negedge clk);
    #1;
    checkOutput("a5Idle", {31'd0, tx}, 32'd1);
    checkOutput("a5BusyLow", {31'd0, rdata[0]}, 32'd0);

    // Overflow, sticky clear and back-to-back frames
    applyStimulus(A_BAUD, 32'd2);
    applyStimulus(A_CTRL, 32'd0);
    for (int b = 1; b <= 5; b++) applyStimulus(A_TX, b);
    readLit("ovfStatus", A_STATUS, 32'h4A);
    applyStimulus(A_STATUS, 32'h8);
    readLit("ovfCleared", A_STATUS, 32'h42);
    applyStimulus(A_CTRL, 32'd1);
    repeat (100) @(negedge clk);
    readLit("drained", A_STATUS, 32'h4);

    // Interrupt timing around a single frame
    applyStimulus(A_CTRL, 32'd3);
    applyStimulus(A_TX, 32'h55);
    checkOutput("intLowQueued", {31'd0, intSig}, 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("intLowInStop", {31'd0, intSig}, 32'd0);
    @(negedge clk);
    checkOutput("intHigh", {31'd0, intSig}, 32'd1);
    applyStimulus(A_CTRL, 32'd1);
    checkOutput("intCleared", {31'd0, intSig}, 32'd0);

    // Clearing tx_en mid-frame finishes the frame and keeps the rest queued
    applyStimulus(A_CTRL, 32'd0);
    applyStimulus(A_TX, 32'h3C);
    applyStimulus(A_TX, 32'hC3);
    applyStimulus(A_CTRL, 32'd1);
    repeat (9) @(negedge clk);
    applyStimulus(A_CTRL, 32'd0);
    repeat (30) @(negedge clk);
    readLit("haltStatus", A_STATUS, 32'h10);
    checkOutput("haltTx", {31'd0, tx}, 32'd1);

    // Reset in the middle of the data bits
    applyStimulus(A_CTRL, 32'd1);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("resetTxHigh", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    readLit("postResetStatus", A_STATUS, 32'h4);
    readLit("postResetCtrl", A_CTRL, 32'h0);
    repeat (30) @(negedge clk);
    checkOutput("postResetTx", {31'd0, tx}, 32'd1);

    // Random traffic, including ignored address/data bits and BAUD changes mid-frame
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 99);
      r1 = $urandom();
      r2 = $urandom();
      if (op < 45) begin
        applyStimulus({r1[31:4], 2'd3, r1[1:0]}, r2);
      end else if (op < 60) begin
        d = r2;
        d[0] = (r2[5:3] != 3'd0);
        applyStimulus({r1[31:4], 2'd0, r1[1:0]}, d);
      end else if (op < 70) begin
        d = r2;
        d[15:0] = 16'($urandom_range(0, 5));
        applyStimulus({r1[31:4], 2'd2, r1[1:0]}, d);
      end else if (op < 75) begin
        applyStimulus({r1[31:4], 2'd1, r1[1:0]}, r2);
      end else if (op < 85) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
      end else begin
        @(negedge clk);
        readModel("randRead", r1);
      end
    end

    applyStimulus(A_CTRL, 32'd1);
    repeat (400) @(negedge clk);
    readModel("finalStatus", A_STATUS);
    readModel("finalCtrl", A_CTRL);
    readModel("finalBaud", A_BAUD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
